// File: rtl/fetch_unit.sv
// Instruction fetch stage for the pipelined DLX datapath.
// Keeps the PC, fetches one word per cycle over a ready-handshaked memory
// port, and loads the IF/ID register. A one-entry skid buffer catches a
// word that arrives while decode is stalled, so no instruction is lost.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h54000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } state_t;

    // Word-aligned reset PC; the two low bits of the PC are always zero.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    logic [31:0] redirect_target;

    logic [31:0] instr_next;
    logic [31:0] pc_out_next;
    logic [31:0] pc_plus4_next;
    logic        instr_valid_next;

    // Skid buffer: holds the word fetched during a stall plus its address.
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic [31:0] skid_pc_inc;
    logic [31:0] skid_instr_next;
    logic [31:0] skid_pc_next;

    // Sequential increments wrap modulo 2^32 without any flag.
    assign pc_inc          = pc + 32'd4;
    assign skid_pc_inc     = skid_pc + 32'd4;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // Memory request is only issued while fetching; the address is the PC.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    // Next-state and IF/ID update logic; redirect outranks every other input.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_next       = instr;
        pc_out_next      = pc_out;
        pc_plus4_next    = pc_plus4;
        instr_valid_next = instr_valid;
        skid_instr_next  = skid_instr;
        skid_pc_next     = skid_pc;

        if (redirect) begin
            pc_next          = redirect_target;
            instr_next       = NOP_INSTR;
            instr_valid_next = 1'b0;
            skid_instr_next  = NOP_INSTR;
            skid_pc_next     = 32'd0;
            state_next       = FETCH;
        end else begin
            case (state)
                IDLE: begin
                    state_next = FETCH;
                end

                FETCH: begin
                    if (imem_ready) begin
                        pc_next = pc_inc;
                        if (stall) begin
                            skid_instr_next = imem_rdata;
                            skid_pc_next    = pc;
                            state_next      = HOLD;
                        end else begin
                            instr_next       = imem_rdata;
                            pc_out_next      = pc;
                            pc_plus4_next    = pc_inc;
                            instr_valid_next = 1'b1;
                        end
                    end else if (!stall) begin
                        instr_next       = NOP_INSTR;
                        instr_valid_next = 1'b0;
                    end
                end

                HOLD: begin
                    if (!stall) begin
                        instr_next       = skid_instr;
                        pc_out_next      = skid_pc;
                        pc_plus4_next    = skid_pc_inc;
                        instr_valid_next = 1'b1;
                        state_next       = FETCH;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, PC, IF/ID and skid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC_ALIGNED;
            instr       <= NOP_INSTR;
            pc_out      <= 32'd0;
            pc_plus4    <= 32'd0;
            instr_valid <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= 32'd0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            pc_out      <= pc_out_next;
            pc_plus4    <= pc_plus4_next;
            instr_valid <= instr_valid_next;
            skid_instr  <= skid_instr_next;
            skid_pc     <= skid_pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of per-cycle vectors for the
// main pipeline behaviour, plus a hand sequence for PC wrap-around.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h54000000;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic        e_valid;
        logic        e_req;
        logic [31:0] e_addr;
        logic        chk_pc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_pc_out;
    logic [31:0] w_pc_plus4;
    logic        w_valid;

    int checks;
    int failures;
    int step;
    vec_t vecs[$];

    // Memory model: every word's content equals its own address.
    assign imem_rdata = imem_addr;
    assign w_rdata    = w_addr;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_rdata  (w_rdata),
        .imem_ready  (imem_ready),
        .instr       (w_instr),
        .pc_out      (w_pc_out),
        .pc_plus4    (w_pc_plus4),
        .instr_valid (w_valid)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic addVec(input logic rst, input logic stl, input logic rdr,
                          input logic [31:0] rpc, input logic rdy,
                          input logic [31:0] e_instr, input logic [31:0] e_pc,
                          input logic [31:0] e_p4, input logic e_valid,
                          input logic e_req, input logic [31:0] e_addr,
                          input logic chk_pc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_p4 = e_p4;
        v.e_valid = e_valid; v.e_req = e_req; v.e_addr = e_addr;
        v.chk_pc = chk_pc;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic rst, input logic stl, input logic rdr,
                                 input logic [31:0] rpc, input logic rdy);
        reset       = rst;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        imem_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        step        = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b1;

        //     rst stl rdr rpc           rdy  instr        pc_out       pc+4         v  req addr         chkpc
        // Reset and steady fetch
        addVec(1, 0, 0, 32'h0,   1, NOP,          32'h0,   32'h0,   0, 0, 32'h0,   1);
        addVec(0, 0, 0, 32'h0,   1, NOP,          32'h0,   32'h0,   0, 1, 32'h0,   1);
        addVec(0, 0, 0, 32'h0,   1, 32'h0,        32'h0,   32'h4,   1, 1, 32'h4,   1);
        addVec(0, 0, 0, 32'h0,   1, 32'h4,        32'h4,   32'h8,   1, 1, 32'h8,   1);
        addVec(0, 0, 0, 32'h0,   1, 32'h8,        32'h8,   32'hC,   1, 1, 32'hC,   1);
        // Stall for three cycles while 0xC is returned, then drain skid
        addVec(0, 1, 0, 32'h0,   1, 32'h8,        32'h8,   32'hC,   1, 0, 32'h10,  1);
        addVec(0, 1, 0, 32'h0,   1, 32'h8,        32'h8,   32'hC,   1, 0, 32'h10,  1);
        addVec(0, 1, 0, 32'h0,   1, 32'h8,        32'h8,   32'hC,   1, 0, 32'h10,  1);
        addVec(0, 0, 0, 32'h0,   1, 32'hC,        32'hC,   32'h10,  1, 1, 32'h10,  1);
        addVec(0, 0, 0, 32'h0,   1, 32'h10,       32'h10,  32'h14,  1, 1, 32'h14,  1);
        addVec(0, 0, 0, 32'h0,   1, 32'h14,       32'h14,  32'h18,  1, 1, 32'h18,  1);
        addVec(0, 0, 0, 32'h0,   1, 32'h18,       32'h18,  32'h1C,  1, 1, 32'h1C,  1);
        addVec(0, 0, 0, 32'h0,   1, 32'h1C,       32'h1C,  32'h20,  1, 1, 32'h20,  1);
        // Memory not ready with stall: IF/ID holds
        addVec(0, 1, 0, 32'h0,   0, 32'h1C,       32'h1C,  32'h20,  1, 1, 32'h20,  1);
        // Memory not ready without stall: two bubbles, then 0x20
        addVec(0, 0, 0, 32'h0,   0, NOP,          32'h0,   32'h0,   0, 1, 32'h20,  0);
        addVec(0, 0, 0, 32'h0,   0, NOP,          32'h0,   32'h0,   0, 1, 32'h20,  0);
        addVec(0, 0, 0, 32'h0,   1, 32'h20,       32'h20,  32'h24,  1, 1, 32'h24,  1);
        // Redirect to 0x103 under stall: flush, refetch at 0x100
        addVec(0, 1, 1, 32'h103, 1, NOP,          32'h0,   32'h0,   0, 1, 32'h100, 0);
        addVec(0, 0, 0, 32'h0,   1, 32'h100,      32'h100, 32'h104, 1, 1, 32'h104, 1);
        // Redirect in HOLD discards the skid word (0x104)
        addVec(0, 1, 0, 32'h0,   1, 32'h100,      32'h100, 32'h104, 1, 0, 32'h108, 1);
        addVec(0, 1, 1, 32'h200, 1, NOP,          32'h0,   32'h0,   0, 1, 32'h200, 0);
        addVec(0, 0, 0, 32'h0,   1, 32'h200,      32'h200, 32'h204, 1, 1, 32'h204, 1);
        // Reset in HOLD with buffered 0x204: never emitted
        addVec(0, 1, 0, 32'h0,   1, 32'h200,      32'h200, 32'h204, 1, 0, 32'h208, 1);
        addVec(1, 1, 0, 32'h0,   1, NOP,          32'h0,   32'h0,   0, 0, 32'h0,   1);
        addVec(0, 0, 0, 32'h0,   1, NOP,          32'h0,   32'h0,   0, 1, 32'h0,   1);
        addVec(0, 0, 0, 32'h0,   1, 32'h0,        32'h0,   32'h4,   1, 1, 32'h4,   1);
        // Redirect taken straight out of IDLE
        addVec(1, 0, 0, 32'h0,   1, NOP,          32'h0,   32'h0,   0, 0, 32'h0,   1);
        addVec(0, 0, 1, 32'h40,  1, NOP,          32'h0,   32'h0,   0, 1, 32'h40,  0);
        addVec(0, 0, 0, 32'h0,   1, 32'h40,       32'h40,  32'h44,  1, 1, 32'h44,  1);

        foreach (vecs[i]) begin
            step = i;
            applyStimulus(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].rpc, vecs[i].rdy);
            checkOutput("instr", instr, vecs[i].e_instr);
            checkOutput("instr_valid", {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            checkOutput("imem_req", {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            checkOutput("imem_addr", imem_addr, vecs[i].e_addr);
            if (vecs[i].chk_pc) begin
                checkOutput("pc_out", pc_out, vecs[i].e_pc);
                checkOutput("pc_plus4", pc_plus4, vecs[i].e_p4);
            end
        end

        // Wrap-around instance: reset PC 0xFFFFFFFC, next fetch at 0.
        step = 100;
        applyStimulus(1, 0, 0, 32'h0, 1);
        checkOutput("wrap_reset_instr", w_instr, NOP);
        checkOutput("wrap_reset_req", {31'd0, w_req}, 32'd0);
        checkOutput("wrap_reset_addr", w_addr, 32'hFFFFFFFC);
        step = 101;
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("wrap_req", {31'd0, w_req}, 32'd1);
        checkOutput("wrap_addr0", w_addr, 32'hFFFFFFFC);
        step = 102;
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("wrap_instr", w_instr, 32'hFFFFFFFC);
        checkOutput("wrap_pc_out", w_pc_out, 32'hFFFFFFFC);
        checkOutput("wrap_pc_plus4", w_pc_plus4, 32'h00000000);
        checkOutput("wrap_valid", {31'd0, w_valid}, 32'd1);
        checkOutput("wrap_addr1", w_addr, 32'h00000000);
        step = 103;
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("wrap_instr2", w_instr, 32'h00000000);
        checkOutput("wrap_pc_out2", w_pc_out, 32'h00000000);
        checkOutput("wrap_pc_plus4_2", w_pc_plus4, 32'h00000004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the pipelined DLX datapath. Holds the PC and issues word fetches over a ready-handshaked instruction-memory port. Applies stall and redirect (taken branch/jump) requests from later stages. Drives the IF/ID pipeline register whose `instr` output feeds the control decoder directly.

Parameters:
RESET_PC  32'h00000000  PC value loaded on reset
NOP_INSTR  32'h54000000  DLX NOP injected as a bubble into IF/ID

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  decode stage cannot accept; IF/ID holds its contents
redirect  input  1  taken branch/jump resolved downstream; flush and refetch
redirect_pc  input  32  target address; bits [1:0] ignored, forced to 00
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, equals current PC
imem_rdata  input  32  instruction word; valid only when imem_ready=1
imem_ready  input  1  memory returns imem_rdata this cycle for imem_addr
instr  output  32  IF/ID instruction register, to control decoder
pc_out  output  32  address of instr
pc_plus4  output  32  pc_out+4, for branch/link adders
instr_valid  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- State machine states: IDLE, FETCH, HOLD. All outputs are registered except imem_req and imem_addr, which decode from state and PC.
- Reset: pc=RESET_PC, state=IDLE, instr=NOP_INSTR, pc_out=0, pc_plus4=0, instr_valid=0, skid buffer cleared. imem_req=0. Reset overrides all other inputs in any state.
- IDLE: imem_req=0. Moves to FETCH on the next edge unconditionally.
- FETCH: imem_req=1 and imem_addr=pc.
  - When imem_ready=0: if stall=0, IF/ID loads a bubble (NOP_INSTR, valid=0); if stall=1, IF/ID holds. pc is unchanged.
  - When imem_ready=1 and stall=0: IF/ID loads {imem_rdata, pc, pc+4, valid=1} and pc<=pc+4. State stays FETCH. Steady-state throughput is 1 instruction per cycle.
  - When imem_ready=1 and stall=1: imem_rdata is captured into the skid buffer together with its pc. pc<=pc+4, state->HOLD, IF/ID holds.
- HOLD: imem_req=0.
  - When stall=1: everything holds.
  - When stall=0: IF/ID loads from the skid buffer (valid=1) and state->FETCH.
  - No instruction is ever dropped or duplicated.
- Redirect has the highest priority below reset and is taken in any non-IDLE state, including while stall=1.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - IF/ID flushed to NOP_INSTR with valid=0, regardless of stall.
  - Skid buffer discarded; state->FETCH.
  - Any imem_rdata returned in the same cycle is discarded.
- Redirect in IDLE: pc is updated and state->FETCH.
- Latency: the instruction at address A appears on instr one edge after the cycle in which imem_ready=1 with imem_addr=A.
- Arithmetic: pc+4 is modulo 2^32. 0xFFFFFFFC wraps to 0x00000000 with no flag.
- imem_addr may change before imem_ready arrives (on redirect). Memory must respond to the address presented in the ready cycle.
- pc[1:0] is always 00.

Test Plan:
1. Release reset; imem_ready=1; memory returns rdata=addr. Required: first instr=0x00000000 with valid=1 two edges after reset release, then 0x4, 0x8 on consecutive cycles; pc_plus4 tracks pc_out+4.
2. Raise stall for 3 cycles while instr=0x8 and 0xC is being returned. Required: instr holds 0x8 and state goes to HOLD. After stall drops, the sequence continues 0xC, 0x10 with no gap duplication or loss.
3. Assert redirect with redirect_pc=0x103 while stall=1. Required: next edge gives instr=0x54000000 and valid=0; following imem_addr=0x100; next valid instr=0x100.
4. Hold imem_ready=0 for 2 cycles at addr 0x20 with stall=0. Required: imem_addr stays 0x20; two bubbles (NOP, valid=0); then instr=0x20.
5. Set RESET_PC=0xFFFFFFFC. Required: first instr pc_out=0xFFFFFFFC with pc_plus4=0x00000000; next fetch addr=0x00000000.
6. Assert reset while in HOLD with buffered data. Required: next edge gives all outputs at reset values; buffered word is never emitted.
